// File: rtl/boot_ctrl.sv
// Boot loader: copies WORDS 32-bit words from SPI flash into instruction memory,
// then releases the CPU core from reset. A stalled flash transfer latches an error.
//
// state | meaning
// IDLE  | one cycle after reset; samples boot_bypass
// CMD   | send flash read command byte
// ADR2  | send flash address bits [23:16]
// ADR1  | send flash address bits [15:8]
// ADR0  | send flash address bits [7:0]
// RDB   | clock in 4 data bytes of the current word
// WR    | one-cycle instruction-memory write of the assembled word
// DONE  | copy finished or bypassed; core released
// ERR   | SPI timeout; core held in reset
module boot_ctrl #(
    parameter int          WORDS      = 128,
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter int          ADDR_W     = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              boot_bypass,
    output logic              spi_start,
    output logic [7:0]        spi_tx,
    input  logic              spi_done,
    input  logic [7:0]        spi_rx,
    output logic              spi_cs_n,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset_n,
    output logic              boot_done,
    output logic              boot_err
);

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);
    localparam logic [7:0]        CMD_READ  = 8'h03;
    localparam logic [9:0]        TMO_LIMIT = 10'h3FF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADR2,
        ST_ADR1,
        ST_ADR0,
        ST_RDB,
        ST_WR,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t            state_q, state_d;
    logic              spi_start_q, spi_start_d;
    logic [7:0]        spi_tx_q, spi_tx_d;
    logic              spi_cs_n_q, spi_cs_n_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              core_reset_n_q, core_reset_n_d;
    logic              boot_done_q, boot_done_d;
    logic              boot_err_q, boot_err_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [9:0]        tmo_cnt_q, tmo_cnt_d;
    logic [23:0]       rx_buf_q, rx_buf_d;

    logic              done_ok;
    logic [9:0]        tmo_nxt;

    always_comb begin
        state_d        = state_q;
        spi_start_d    = 1'b0;
        spi_tx_d       = spi_tx_q;
        spi_cs_n_d     = spi_cs_n_q;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        core_reset_n_d = core_reset_n_q;
        boot_done_d    = boot_done_q;
        boot_err_d     = boot_err_q;
        word_cnt_d     = word_cnt_q;
        byte_cnt_d     = byte_cnt_q;
        tmo_cnt_d      = tmo_cnt_q;
        rx_buf_d       = rx_buf_q;

        // A done pulse coinciding with our own start pulse belongs to nothing we issued.
        done_ok = spi_done && !spi_start_q;
        tmo_nxt = tmo_cnt_q + 10'd1;

        case (state_q)
            ST_IDLE: begin
                if (boot_bypass) begin
                    state_d        = ST_DONE;
                    core_reset_n_d = 1'b1;
                    boot_done_d    = 1'b1;
                end else begin
                    state_d     = ST_CMD;
                    spi_start_d = 1'b1;
                    spi_tx_d    = CMD_READ;
                    spi_cs_n_d  = 1'b0;
                    tmo_cnt_d   = '0;
                end
            end

            ST_CMD, ST_ADR2, ST_ADR1, ST_ADR0, ST_RDB: begin
                if (done_ok) begin
                    tmo_cnt_d = '0;
                    case (state_q)
                        ST_CMD: begin
                            state_d     = ST_ADR2;
                            spi_start_d = 1'b1;
                            spi_tx_d    = FLASH_BASE[23:16];
                        end
                        ST_ADR2: begin
                            state_d     = ST_ADR1;
                            spi_start_d = 1'b1;
                            spi_tx_d    = FLASH_BASE[15:8];
                        end
                        ST_ADR1: begin
                            state_d     = ST_ADR0;
                            spi_start_d = 1'b1;
                            spi_tx_d    = FLASH_BASE[7:0];
                        end
                        ST_ADR0: begin
                            state_d     = ST_RDB;
                            spi_start_d = 1'b1;
                            spi_tx_d    = 8'h00;
                            byte_cnt_d  = 2'd0;
                        end
                        default: begin
                            if (byte_cnt_q == 2'd3) begin
                                state_d      = ST_WR;
                                imem_we_d    = 1'b1;
                                imem_addr_d  = word_cnt_q;
                                imem_wdata_d = {spi_rx, rx_buf_q};
                                if (word_cnt_q == LAST_WORD) begin
                                    spi_cs_n_d = 1'b1;
                                end
                            end else begin
                                case (byte_cnt_q)
                                    2'd0:    rx_buf_d[7:0]   = spi_rx;
                                    2'd1:    rx_buf_d[15:8]  = spi_rx;
                                    default: rx_buf_d[23:16] = spi_rx;
                                endcase
                                byte_cnt_d  = byte_cnt_q + 2'd1;
                                spi_start_d = 1'b1;
                                spi_tx_d    = 8'h00;
                            end
                        end
                    endcase
                end else if (tmo_nxt == TMO_LIMIT) begin
                    state_d    = ST_ERR;
                    spi_cs_n_d = 1'b1;
                    boot_err_d = 1'b1;
                    tmo_cnt_d  = tmo_nxt;
                end else begin
                    tmo_cnt_d = tmo_nxt;
                end
            end

            ST_WR: begin
                if (word_cnt_q == LAST_WORD) begin
                    state_d        = ST_DONE;
                    core_reset_n_d = 1'b1;
                    boot_done_d    = 1'b1;
                end else begin
                    // Continuous read: flash auto-increments, so no new command phase.
                    state_d     = ST_RDB;
                    word_cnt_d  = word_cnt_q + 1'b1;
                    byte_cnt_d  = 2'd0;
                    spi_start_d = 1'b1;
                    spi_tx_d    = 8'h00;
                    tmo_cnt_d   = '0;
                end
            end

            ST_DONE, ST_ERR: begin
            end

            default: begin
                state_d    = ST_IDLE;
                spi_cs_n_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            spi_start_q    <= 1'b0;
            spi_tx_q       <= 8'h00;
            spi_cs_n_q     <= 1'b1;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= 32'h0;
            core_reset_n_q <= 1'b0;
            boot_done_q    <= 1'b0;
            boot_err_q     <= 1'b0;
            word_cnt_q     <= '0;
            byte_cnt_q     <= 2'd0;
            tmo_cnt_q      <= 10'd0;
            rx_buf_q       <= 24'h0;
        end else begin
            state_q        <= state_d;
            spi_start_q    <= spi_start_d;
            spi_tx_q       <= spi_tx_d;
            spi_cs_n_q     <= spi_cs_n_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            core_reset_n_q <= core_reset_n_d;
            boot_done_q    <= boot_done_d;
            boot_err_q     <= boot_err_d;
            word_cnt_q     <= word_cnt_d;
            byte_cnt_q     <= byte_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            rx_buf_q       <= rx_buf_d;
        end
    end

    assign spi_start    = spi_start_q;
    assign spi_tx       = spi_tx_q;
    assign spi_cs_n     = spi_cs_n_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign core_reset_n = core_reset_n_q;
    assign boot_done    = boot_done_q;
    assign boot_err     = boot_err_q;

endmodule

// File: tb/tb_boot_ctrl.sv
// Testbench for boot_ctrl with WORDS=4: a behavioural SPI flash model feeds bytes
// 00,01,02,...; expected SPI bytes and memory writes are queued and compared on output.
module tb_boot_ctrl;

    localparam int WORDS  = 4;
    localparam int ADDR_W = 7;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              boot_bypass = 1'b0;
    logic              spi_start;
    logic [7:0]        spi_tx;
    logic              spi_done = 1'b0;
    logic [7:0]        spi_rx = 8'h00;
    logic              spi_cs_n;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset_n;
    logic              boot_done;
    logic              boot_err;

    always #5 clk = ~clk;

    boot_ctrl #(.WORDS(WORDS), .FLASH_BASE(24'h000000), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .boot_bypass  (boot_bypass),
        .spi_start    (spi_start),
        .spi_tx       (spi_tx),
        .spi_done     (spi_done),
        .spi_rx       (spi_rx),
        .spi_cs_n     (spi_cs_n),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_reset_n (core_reset_n),
        .boot_done    (boot_done),
        .boot_err     (boot_err)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [7:0] exp_tx[$];
    wr_t  exp_wr[$];

    // flash model controls and observations
    int   idx = 0;
    bit   pending = 0;
    int   wait_cnt = 0;
    logic [7:0] rx_next = 8'h00;
    int   lat_cfg = 2;
    bit   stall_en = 0;
    bit   late_en = 0;
    int   late_idx = 5;
    bit   spur_en = 0;
    int   stall_cyc = -1;
    int   start_count = 0;
    int   we_count = 0;
    int   last_we_cyc = -100;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin : flash_model
        logic [7:0] e;
        int d;
        wr_t w;
        forever begin
            @(posedge clk); #1;
            spi_done = 1'b0;
            if (reset || spi_cs_n) begin
                idx = 0;
                pending = 0;
            end else if (pending) begin
                if (wait_cnt > 1) wait_cnt--;
                else begin
                    spi_done = 1'b1;
                    spi_rx = rx_next;
                    pending = 0;
                end
            end
            if (spi_start === 1'b1 && !reset) begin
                start_count++;
                checks++;
                if (exp_tx.size() == 0) begin
                    errors++;
                    $display("FAIL spi_start_unexpected: got spi_start with tx=%h, required no transfer", spi_tx);
                end else begin
                    e = exp_tx.pop_front();
                    if (spi_tx !== e) begin
                        errors++;
                        $display("FAIL spi_tx[%0d]: got %h, required %h", idx, spi_tx, e);
                    end
                end
                if (idx >= 4) begin
                    d = idx - 4;
                    rx_next = 8'(d);
                    if ((d % 4) == 3) begin
                        w.addr = ADDR_W'(d / 4);
                        w.data = {8'(d), 8'(d - 1), 8'(d - 2), 8'(d - 3)};
                        exp_wr.push_back(w);
                    end
                end else begin
                    rx_next = 8'hFF;
                end
                if (stall_en && idx == 9) begin
                    stall_cyc = cyc;
                    pending = 0;
                end else begin
                    pending = 1;
                    wait_cnt = (late_en && idx == late_idx) ? 1022 : lat_cfg;
                end
                if (spur_en && (idx == 0 || idx == 5)) begin
                    #1;
                    spi_done = 1'b1;
                    spi_rx = 8'hEE;
                end
                idx++;
            end
        end
    end

    initial begin : wr_monitor
        wr_t e;
        forever begin
            @(posedge clk); #1;
            if (imem_we === 1'b1) begin
                we_count++;
                last_we_cyc = cyc;
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL imem_write_unexpected: got addr=%0d data=%h, required no write", imem_addr, imem_wdata);
                end else begin
                    e = exp_wr.pop_front();
                    if (imem_addr !== e.addr || imem_wdata !== e.data) begin
                        errors++;
                        $display("FAIL imem_write: got addr=%0d data=%h, required addr=%0d data=%h",
                                 imem_addr, imem_wdata, e.addr, e.data);
                    end
                end
                if (spur_en) begin
                    #1;
                    spi_done = 1'b1;
                    spi_rx = 8'hEE;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        exp_tx.delete();
        exp_wr.delete();
        we_count = 0;
        start_count = 0;
        stall_en = 0;
        late_en = 0;
        spur_en = 0;
        stall_cyc = -1;
        lat_cfg = 2;
    endtask

    task automatic push_boot_tx();
        exp_tx.push_back(8'h03);
        repeat (3) exp_tx.push_back(8'h00);
        repeat (4 * WORDS) exp_tx.push_back(8'h00);
    endtask

    task automatic wait_boot(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (boot_done === 1'b1 || boot_err === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({spi_start, spi_tx, spi_cs_n} !== {1'b0, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL reset_spi: got start=%b tx=%h cs_n=%b, required 0 00 1", spi_start, spi_tx, spi_cs_n);
        end
        checks++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b0, 7'd0, 32'h0}) begin
            errors++;
            $display("FAIL reset_imem: got we=%b addr=%0d data=%h, required 0 0 0", imem_we, imem_addr, imem_wdata);
        end
        checks++;
        if ({core_reset_n, boot_done, boot_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_status: got core_reset_n=%b done=%b err=%b, required 000", core_reset_n, boot_done, boot_err);
        end
    endtask

    task automatic check_normal_end(input string tag, input bit ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: got no boot_done/boot_err, required boot_done", tag);
        end
        checks++;
        if ({boot_done, core_reset_n, boot_err, spi_cs_n} !== 4'b1101) begin
            errors++;
            $display("FAIL %s_status: got done=%b core_reset_n=%b err=%b cs_n=%b, required 1 1 0 1",
                     tag, boot_done, core_reset_n, boot_err, spi_cs_n);
        end
        checks++;
        if (we_count != WORDS) begin
            errors++;
            $display("FAIL %s_we_count: got %0d, required %0d", tag, we_count, WORDS);
        end
        checks++;
        if (exp_tx.size() != 0 || exp_wr.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover: got tx_left=%0d wr_left=%0d, required 0 0", tag, exp_tx.size(), exp_wr.size());
        end
    endtask

    task automatic test_normal();
        bit ok;
        apply_reset();
        lat_cfg = 1;
        push_boot_tx();
        reset = 1'b0;
        wait_boot(2000, ok);
        checks++;
        if (cyc != last_we_cyc + 1) begin
            errors++;
            $display("FAIL normal_release_timing: got core release %0d cycles after last write, required 1", cyc - last_we_cyc);
        end
        check_normal_end("normal", ok);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (imem_addr !== 7'd3 || imem_wdata !== 32'h0F0E0D0C || imem_we !== 1'b0) begin
            errors++;
            $display("FAIL normal_hold: got we=%b addr=%0d data=%h, required 0 3 0f0e0d0c", imem_we, imem_addr, imem_wdata);
        end
    endtask

    task automatic test_bypass();
        apply_reset();
        boot_bypass = 1'b1;
        reset = 1'b0;
        checks++;
        if (boot_done !== 1'b0 || core_reset_n !== 1'b0) begin
            errors++;
            $display("FAIL bypass_idle: got done=%b core_reset_n=%b, required 0 0", boot_done, core_reset_n);
        end
        @(posedge clk); #1;
        checks++;
        if ({boot_done, core_reset_n, boot_err, spi_cs_n} !== 4'b1101) begin
            errors++;
            $display("FAIL bypass_done: got done=%b core_reset_n=%b err=%b cs_n=%b, required 1 1 0 1",
                     boot_done, core_reset_n, boot_err, spi_cs_n);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (start_count != 0 || spi_cs_n !== 1'b1 || boot_done !== 1'b1) begin
            errors++;
            $display("FAIL bypass_quiet: got starts=%0d cs_n=%b done=%b, required 0 1 1", start_count, spi_cs_n, boot_done);
        end
        reset = 1'b1;
        boot_bypass = 1'b0;
    endtask

    task automatic test_stall();
        bit ok;
        apply_reset();
        stall_en = 1;
        exp_tx.push_back(8'h03);
        repeat (3) exp_tx.push_back(8'h00);
        repeat (6) exp_tx.push_back(8'h00);
        reset = 1'b0;
        wait_boot(1500, ok);
        checks++;
        if (!ok || boot_err !== 1'b1) begin
            errors++;
            $display("FAIL stall_err: got ok=%0d boot_err=%b, required boot_err 1", ok, boot_err);
        end
        checks++;
        if (cyc - stall_cyc != 1023) begin
            errors++;
            $display("FAIL stall_latency: got %0d cycles, required 1023", cyc - stall_cyc);
        end
        checks++;
        if ({spi_cs_n, core_reset_n, boot_done} !== 3'b100) begin
            errors++;
            $display("FAIL stall_status: got cs_n=%b core_reset_n=%b done=%b, required 1 0 0", spi_cs_n, core_reset_n, boot_done);
        end
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (we_count != 1 || start_count != 10 || exp_wr.size() != 0 || boot_err !== 1'b1) begin
            errors++;
            $display("FAIL stall_after: got writes=%0d starts=%0d wr_left=%0d err=%b, required 1 10 0 1",
                     we_count, start_count, exp_wr.size(), boot_err);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit hit;
        apply_reset();
        exp_tx.push_back(8'h03);
        repeat (2) exp_tx.push_back(8'h00);
        reset = 1'b0;
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #2;
            if (idx == 3) begin
                hit = 1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rmid_reach_adr1: got idx=%0d, required 3", idx);
        end
        reset = 1'b1;
        @(posedge clk); #2;
        checks++;
        if (spi_cs_n !== 1'b1 || imem_we !== 1'b0 || spi_start !== 1'b0) begin
            errors++;
            $display("FAIL rmid_abort: got cs_n=%b we=%b start=%b, required 1 0 0", spi_cs_n, imem_we, spi_start);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_tx.size() != 0 || we_count != 0) begin
            errors++;
            $display("FAIL rmid_partial: got tx_left=%0d writes=%0d, required 0 0", exp_tx.size(), we_count);
        end
        push_boot_tx();
        reset = 1'b0;
        wait_boot(2000, ok);
        check_normal_end("rmid", ok);
    endtask

    task automatic test_spurious();
        bit ok;
        apply_reset();
        spur_en = 1;
        lat_cfg = 3;
        push_boot_tx();
        reset = 1'b0;
        #1;
        spi_done = 1'b1;
        spi_rx = 8'hEE;
        wait_boot(2000, ok);
        check_normal_end("spur", ok);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            spi_done = 1'b1;
            spi_rx = 8'hEE;
        end
        @(posedge clk); #1;
        checks++;
        if ({boot_done, core_reset_n, spi_cs_n, boot_err} !== 4'b1110 || we_count != WORDS ||
            imem_wdata !== 32'h0F0E0D0C || imem_addr !== 7'd3) begin
            errors++;
            $display("FAIL spur_done_state: got done=%b core=%b cs_n=%b err=%b writes=%0d data=%h addr=%0d, required 1 1 1 0 4 0f0e0d0c 3",
                     boot_done, core_reset_n, spi_cs_n, boot_err, we_count, imem_wdata, imem_addr);
        end
    endtask

    task automatic test_late();
        bit ok;
        apply_reset();
        late_en = 1;
        late_idx = 5;
        push_boot_tx();
        reset = 1'b0;
        wait_boot(3000, ok);
        check_normal_end("late", ok);
    endtask

    initial begin : main
        test_reset();
        test_normal();
        test_bypass();
        test_stall();
        test_reset_mid();
        test_spurious();
        test_late();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
